// File: rtl/sg_pkg.sv
// Shared scatter-gather definitions: SG word field layout, list FSM states, entry payload.
package sg_pkg;

    localparam int unsigned SG_WORD_W      = 128;
    localparam int unsigned SG_FIELD_W     = 32;
    localparam int unsigned SG_ADDR_LO_LSB = 0;
    localparam int unsigned SG_ADDR_HI_LSB = 32;
    localparam int unsigned SG_LEN_LSB     = 64;
    localparam int unsigned SG_RSVD_LSB    = 96;

    typedef enum logic [1:0] {
        SG_IDLE  = 2'd0,
        SG_FILL  = 2'd1,
        SG_DRAIN = 2'd2,
        SG_DONE  = 2'd3
    } sg_state_e;

    // One buffered element: end-of-list tag plus the packed SG word.
    typedef struct packed {
        logic                 last;
        logic [SG_WORD_W-1:0] word;
    } sg_entry_t;

    // Ceiling log2 for constant sizing (returns 0 for values <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'(1) << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sg_elem_buf.sv
// Small register FIFO holding {LAST,word} entries with registered full/empty flags.
module sg_elem_buf
    import sg_pkg::*;
#(
    parameter int unsigned C_DEPTH = 2,
    parameter int unsigned C_WIDTH = 129
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [C_WIDTH-1:0] din_i,
    output logic [C_WIDTH-1:0] dout_o,
    output logic               full_nxt_o,
    output logic               empty_o
);

    localparam int unsigned PTR_W = clog2(C_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               full_q;
    logic               empty_q;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!do_push && do_pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    assign full_nxt_o = (occ_d == OCC_W'(C_DEPTH));

    // Pointer, occupancy and flag registers; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q   <= occ_d;
            full_q  <= full_nxt_o;
            empty_q <= (occ_d == '0);
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Head is forced to zero while empty so stale or unwritten storage never shows.
    assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o = empty_q;

endmodule

// File: rtl/sg_list_writer_128.sv
// SG list producer: packs {ADDR,LEN} elements into 128-bit words for a sync_fifo.
// Optional length checking is enabled by defining SG_LIST_WRITER_LEN_CHECK_EN.
module sg_list_writer_128
    import sg_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH  = 128,
    parameter int unsigned C_DEPTH       = 2,
    parameter int unsigned C_COUNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ELEM_WEN,
    input  logic [63:0]              ELEM_ADDR,
    input  logic [31:0]              ELEM_LEN,
    input  logic                     ELEM_LAST,
    output logic                     ELEM_FULL,
    output logic [C_DATA_WIDTH-1:0]  BUF_DATA,
    output logic                     BUF_WEN,
    input  logic                     BUF_FULL,
    output logic                     DONE,
    output logic [C_COUNT_WIDTH-1:0] ELEM_COUNT,
    output logic                     ERR
);

    localparam int unsigned ENT_W = SG_WORD_W + 1;

    if (C_DATA_WIDTH != SG_WORD_W) begin : g_bad_width
        $error("sg_list_writer_128: only C_DATA_WIDTH=128 is supported");
    end
    if ((C_DEPTH < 2) || ((C_DEPTH & (C_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sg_list_writer_128: C_DEPTH must be a power of two and >= 2");
    end

    sg_state_e                state_q;
    sg_state_e                state_d;
    logic                     elem_full_q;
    logic                     elem_full_d;
    logic [C_COUNT_WIDTH-1:0] count_q;
    logic [C_COUNT_WIDTH-1:0] count_d;
    logic                     accept_c;
    logic                     keep_c;
    logic                     len_bad_c;
    logic                     drop_end_c;
    logic [SG_WORD_W-1:0]     word_c;
    sg_entry_t                ent_in_c;
    sg_entry_t                ent_head_c;
    logic [ENT_W-1:0]         buf_dout;
    logic                     buf_empty;
    logic                     buf_full_nxt;

    // Pack the element into the SG word layout.
    always_comb begin
        word_c = '0;
        word_c[SG_ADDR_LO_LSB +: SG_FIELD_W] = ELEM_ADDR[31:0];
        word_c[SG_ADDR_HI_LSB +: SG_FIELD_W] = ELEM_ADDR[63:32];
        word_c[SG_LEN_LSB     +: SG_FIELD_W] = ELEM_LEN;
        word_c[SG_RSVD_LSB    +: SG_FIELD_W] = '0;
    end

    assign ent_in_c = {ELEM_LAST, word_c};

`ifdef SG_LIST_WRITER_LEN_CHECK_EN
    logic err_q;
    logic last_drop_q;

    assign len_bad_c = (ELEM_LEN == '0) || (ELEM_LEN[1:0] != 2'b00);

    // Sticky error and "LAST was dropped" marker that lets DRAIN finish on an empty buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q       <= 1'b0;
            last_drop_q <= 1'b0;
        end else begin
            if (accept_c && len_bad_c) begin
                err_q <= 1'b1;
            end
            if (state_q == SG_DONE) begin
                last_drop_q <= 1'b0;
            end else if (accept_c && len_bad_c && ELEM_LAST) begin
                last_drop_q <= 1'b1;
            end
        end
    end

    assign ERR        = err_q;
    assign drop_end_c = last_drop_q & buf_empty;
`else
    assign len_bad_c  = 1'b0;
    assign ERR        = 1'b0;
    assign drop_end_c = 1'b0;
`endif

    assign accept_c   = ELEM_WEN & ~elem_full_q;
    assign keep_c     = accept_c & ~len_bad_c;
    assign ent_head_c = buf_dout;
    assign BUF_WEN    = ~buf_empty & ~BUF_FULL;
    assign BUF_DATA   = ent_head_c.word;

    sg_elem_buf #(
        .C_DEPTH (C_DEPTH),
        .C_WIDTH (ENT_W)
    ) u_buf (
        .clk        (CLK),
        .rst        (RST),
        .push_i     (keep_c),
        .pop_i      (BUF_WEN),
        .din_i      (ent_in_c),
        .dout_o     (buf_dout),
        .full_nxt_o (buf_full_nxt),
        .empty_o    (buf_empty)
    );

    // List FSM, saturating element counter and next ELEM_FULL.
    always_comb begin
        state_d = state_q;
        count_d = count_q;

        case (state_q)
            SG_IDLE: begin
                if (accept_c) begin
                    state_d = ELEM_LAST ? SG_DRAIN : SG_FILL;
                end
            end
            SG_FILL: begin
                if (accept_c && ELEM_LAST) begin
                    state_d = SG_DRAIN;
                end
            end
            SG_DRAIN: begin
                if ((BUF_WEN && ent_head_c.last) || drop_end_c) begin
                    state_d = SG_DONE;
                end
            end
            SG_DONE: begin
                state_d = SG_IDLE;
            end
            default: begin
                state_d = SG_IDLE;
            end
        endcase

        if (state_q == SG_DONE) begin
            count_d = '0;
        end else if (BUF_WEN && (count_q != '1)) begin
            count_d = count_q + C_COUNT_WIDTH'(1);
        end

        elem_full_d = buf_full_nxt || (state_d == SG_DRAIN) || (state_d == SG_DONE);
    end

    // State, counter and ELEM_FULL registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= SG_IDLE;
            count_q     <= '0;
            elem_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            elem_full_q <= elem_full_d;
        end
    end

    assign ELEM_FULL  = elem_full_q;
    assign DONE       = (state_q == SG_DONE);
    assign ELEM_COUNT = count_q;

endmodule

// File: tb/tb_sg_list_writer_128.sv
// Self-checking bench for sg_list_writer_128: queue-based reference plus directed literal checks.
module tb_sg_list_writer_128;

    localparam int unsigned DEPTH = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ELEM_WEN = 1'b0;
    logic [63:0]  ELEM_ADDR = '0;
    logic [31:0]  ELEM_LEN = '0;
    logic         ELEM_LAST = 1'b0;
    logic         ELEM_FULL;
    logic [127:0] BUF_DATA;
    logic         BUF_WEN;
    logic         BUF_FULL = 1'b0;
    logic         DONE;
    logic [15:0]  ELEM_COUNT;
    logic         ERR;

    sg_list_writer_128 #(
        .C_DATA_WIDTH  (128),
        .C_DEPTH       (DEPTH),
        .C_COUNT_WIDTH (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ELEM_WEN   (ELEM_WEN),
        .ELEM_ADDR  (ELEM_ADDR),
        .ELEM_LEN   (ELEM_LEN),
        .ELEM_LAST  (ELEM_LAST),
        .ELEM_FULL  (ELEM_FULL),
        .BUF_DATA   (BUF_DATA),
        .BUF_WEN    (BUF_WEN),
        .BUF_FULL   (BUF_FULL),
        .DONE       (DONE),
        .ELEM_COUNT (ELEM_COUNT),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [127:0] pack(input logic [63:0] a, input logic [31:0] l);
        return {32'h0, l, a};
    endfunction

    function automatic bit len_bad(input logic [31:0] l);
`ifdef SG_LIST_WRITER_LEN_CHECK_EN
        return (l == 32'h0) || (l[1:0] != 2'b00);
`else
        return (l === 32'hx);
`endif
    endfunction

    // Reference: the element buffer as a queue plus the list phase (0 idle,1 fill,2 drain,3 done).
    typedef struct {
        bit           last;
        logic [127:0] w;
    } ment_t;

    ment_t mq[$];
    int    m_phase = 0;
    int    m_count = 0;
    bit    m_err   = 0;
    bit    m_ldrop = 0;
    int    cyc     = 0;

    function automatic bit m_full();
        return (mq.size() == DEPTH) || (m_phase >= 2);
    endfunction

    function automatic bit m_wen();
        return (mq.size() > 0) && !BUF_FULL;
    endfunction

    task automatic model_step();
        bit    acc, pop, plast, bad;
        int    nph;
        ment_t e;
        if (RST) begin
            mq.delete();
            m_phase = 0; m_count = 0; m_err = 0; m_ldrop = 0;
            return;
        end
        acc   = ELEM_WEN && !m_full();
        pop   = m_wen();
        plast = pop && mq[0].last;
        bad   = acc && len_bad(ELEM_LEN);
        nph   = m_phase;
        case (m_phase)
            0: if (acc) nph = ELEM_LAST ? 2 : 1;
            1: if (acc && ELEM_LAST) nph = 2;
            2: if (plast || (m_ldrop && mq.size() == 0)) nph = 3;
            default: nph = 0;
        endcase
        if (m_phase == 3) m_count = 0;
        else if (pop && m_count < 65535) m_count++;
        if (bad) m_err = 1;
        if (m_phase == 3) m_ldrop = 0;
        else if (bad && ELEM_LAST) m_ldrop = 1;
        if (pop) void'(mq.pop_front());
        if (acc && !bad) begin
            e.last = ELEM_LAST;
            e.w    = pack(ELEM_ADDR, ELEM_LEN);
            mq.push_back(e);
        end
        m_phase = nph;
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
        model_step();
    end

    // Output log and per-cycle comparison against the reference.
    logic [127:0] log_q[$];
    int           wen_cyc[$];
    int           done_cnt   = 0;
    bit           win2       = 0;
    bit           full_seen2 = 0;

    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            chk("elem_full", ELEM_FULL, m_full());
            chk("buf_wen", BUF_WEN, m_wen());
            if (m_wen()) chk("buf_data", BUF_DATA, mq[0].w);
            chk("done", DONE, m_phase == 3);
            chk("elem_count", ELEM_COUNT, m_count);
            chk("err", ERR, m_err);
            if (DONE) done_cnt++;
            if (BUF_WEN) begin
                log_q.push_back(BUF_DATA);
                wen_cyc.push_back(cyc);
            end
            if (win2 && ELEM_FULL) full_seen2 = 1;
        end
    end

    bit rand_bp = 0;

    task automatic push_elem(input logic [63:0] a, input logic [31:0] l, input bit last);
        bit f, ok;
        ok = 0;
        ELEM_WEN = 1; ELEM_ADDR = a; ELEM_LEN = l; ELEM_LAST = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rand_bp) BUF_FULL = ($urandom_range(0, 3) == 0);
            @(negedge CLK); f = ELEM_FULL;
            @(posedge CLK); #1;
            if (!f) ok = 1;
        end
        ELEM_WEN = 0;
        if (!ok) begin
            n_tot++;
            $display("FAIL push_timeout: element %h not accepted, required within 200 cycles", a);
        end
    endtask

    task automatic wait_done(output logic [15:0] c);
        bit got;
        got = 0; c = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (DONE) begin got = 1; c = ELEM_COUNT; end
            @(posedge CLK); #1;
        end
        if (!got) begin
            n_tot++;
            $display("FAIL done_timeout: no DONE seen, required within 300 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [127:0] exp_w[$];
    logic [15:0]  c;
    logic [63:0]  a3 [3];
    logic [31:0]  l3 [3];
    logic [63:0]  ra;
    logic [31:0]  rl;
    int           k, nacc, first_pop, acc_cyc;
    bit           f, wen_seen;

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 0;

        // Reset values
        @(negedge CLK);
        chk("rst_buf_data", BUF_DATA, 128'h0);
        chk("rst_elem_full", ELEM_FULL, 1'b0);
        chk("rst_buf_wen", BUF_WEN, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_count", ELEM_COUNT, 16'h0);
        chk("rst_err", ERR, 1'b0);
        @(posedge CLK); #1;

        // 1: single LAST element
        push_elem(64'h0000_0001_2345_6780, 32'h1000, 1);
        @(negedge CLK);
        chk("t1_wen", BUF_WEN, 1'b1);
        chk("t1_data", BUF_DATA, 128'h00000000_00001000_00000001_23456780);
        chk("t1_count_pre", ELEM_COUNT, 16'd0);
        @(negedge CLK);
        chk("t1_done", DONE, 1'b1);
        chk("t1_count_done", ELEM_COUNT, 16'd1);
        @(negedge CLK);
        chk("t1_done_off", DONE, 1'b0);
        chk("t1_count_clr", ELEM_COUNT, 16'd0);
        @(posedge CLK); #1;

        // 2: eight back-to-back elements
        log_q.delete(); wen_cyc.delete(); exp_w.delete(); done_cnt = 0; full_seen2 = 0; win2 = 1;
        for (int i = 0; i < 8; i++) begin
            ra = 64'h1000_0000_0000_0000 + 64'(i) * 64'h100;
            rl = 32'h40 + 32'(i) * 32'h10;
            exp_w.push_back(pack(ra, rl));
            push_elem(ra, rl, i == 7);
        end
        win2 = 0;
        wait_done(c);
        chk("t2_words", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) chk($sformatf("t2_word%0d", i), log_q[i], exp_w[i]);
        if (wen_cyc.size() == 8) chk("t2_nogap", wen_cyc[7] - wen_cyc[0], 7);
        chk("t2_full_never", full_seen2, 1'b0);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_count_at_done", c, 16'd8);

        // 3: backpressure with three elements offered
        log_q.delete(); exp_w.delete(); done_cnt = 0;
        a3[0] = 64'hA000_0000_0000_1000; l3[0] = 32'h100;
        a3[1] = 64'hA000_0000_0000_2000; l3[1] = 32'h200;
        a3[2] = 64'hA000_0000_0000_3000; l3[2] = 32'h300;
        for (int i = 0; i < 3; i++) exp_w.push_back(pack(a3[i], l3[i]));
        BUF_FULL = 1; k = 0; nacc = 0; wen_seen = 0;
        for (int i = 0; i < 10; i++) begin
            ELEM_WEN = 1; ELEM_ADDR = a3[k]; ELEM_LEN = l3[k]; ELEM_LAST = (k == 2);
            @(negedge CLK); f = ELEM_FULL; if (BUF_WEN) wen_seen = 1;
            @(posedge CLK); #1;
            if (!f) begin nacc++; if (k < 2) k++; end
        end
        @(negedge CLK);
        chk("t3_accepted", nacc, 2);
        chk("t3_full", ELEM_FULL, 1'b1);
        chk("t3_no_wen", wen_seen, 1'b0);
        @(posedge CLK); #1;
        BUF_FULL = 0; first_pop = -1; acc_cyc = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK); f = ELEM_FULL;
            if (BUF_WEN && first_pop < 0) first_pop = cyc;
            if (!f) acc_cyc = cyc;
            @(posedge CLK); #1;
            if (!f) break;
        end
        ELEM_WEN = 0;
        chk("t3_third_after_pop", acc_cyc - first_pop, 1);
        wait_done(c);
        chk("t3_words", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) chk($sformatf("t3_word%0d", i), log_q[i], exp_w[i]);
        chk("t3_done_cnt", done_cnt, 1);

        // 4: reset mid-list
        BUF_FULL = 1;
        push_elem(64'h0000_0000_DEAD_0000, 32'h20, 0);
        RST = 1;
        @(posedge CLK); #1;
        RST = 0; log_q.delete(); done_cnt = 0;
        @(negedge CLK);
        chk("t4_wen", BUF_WEN, 1'b0);
        chk("t4_count", ELEM_COUNT, 16'd0);
        chk("t4_full", ELEM_FULL, 1'b0);
        chk("t4_done", DONE, 1'b0);
        @(posedge CLK); #1;
        BUF_FULL = 0;
        push_elem(64'h0000_0000_BEEF_0000, 32'h24, 1);
        wait_done(c);
        chk("t4_words", log_q.size(), 1);
        if (log_q.size() > 0) chk("t4_first", log_q[0], 128'h00000000_00000024_00000000_BEEF0000);
        chk("t4_done_cnt", done_cnt, 1);

        // 5: length check (LEN=0, LEN=3, LEN=8 with LAST)
        log_q.delete(); done_cnt = 0;
        push_elem(64'h5000, 32'd0, 0);
        push_elem(64'h5100, 32'd3, 0);
        push_elem(64'h5200, 32'd8, 1);
        wait_done(c);
`ifdef SG_LIST_WRITER_LEN_CHECK_EN
        chk("t5_words", log_q.size(), 1);
        if (log_q.size() > 0) chk("t5_word", log_q[0], 128'h00000000_00000008_00000000_00005200);
        chk("t5_err", ERR, 1'b1);
        chk("t5_count", c, 16'd1);
`else
        chk("t5_words", log_q.size(), 3);
        if (log_q.size() > 1) chk("t5_word1", log_q[1], 128'h00000000_00000003_00000000_00005100);
        chk("t5_err", ERR, 1'b0);
        chk("t5_count", c, 16'd3);
`endif
        chk("t5_done_cnt", done_cnt, 1);

        // 5b: LAST element with a bad length
        log_q.delete(); done_cnt = 0;
        push_elem(64'h5300, 32'd16, 0);
        push_elem(64'h5400, 32'd0, 1);
        wait_done(c);
`ifdef SG_LIST_WRITER_LEN_CHECK_EN
        chk("t5b_words", log_q.size(), 1);
        chk("t5b_count", c, 16'd1);
`else
        chk("t5b_words", log_q.size(), 2);
        chk("t5b_count", c, 16'd2);
`endif
        chk("t5b_done_cnt", done_cnt, 1);

        // 6: longer list with random backpressure
        log_q.delete(); exp_w.delete(); done_cnt = 0; rand_bp = 1;
        for (int i = 0; i < 30; i++) begin
            ra = {32'($urandom), 32'($urandom)};
            rl = 32'($urandom_range(1, 4096)) << 2;
            exp_w.push_back(pack(ra, rl));
            push_elem(ra, rl, i == 29);
        end
        rand_bp = 0; BUF_FULL = 0;
        wait_done(c);
        chk("t6_words", log_q.size(), 30);
        for (int i = 0; i < 30 && i < log_q.size(); i++) chk($sformatf("t6_word%0d", i), log_q[i], exp_w[i]);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_count", c, 16'd30);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
